// File: rtl/conv1d_requant_if.sv
`default_nettype none
// ============================================================================
// Module   : conv1d_requant_if
// Purpose  : Accumulator-in / packed-word-out stream bundle for conv1d_requant.
// Revision : 1.0  initial release
// ============================================================================
interface conv1d_requant_if #(
    parameter int ACC_WIDTH = 32,
    parameter int OUT_WIDTH = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic [ACC_WIDTH-1:0]   in_acc;
    logic                   in_last;
    logic                   out_valid;
    logic                   out_ready;
    logic [OUT_WIDTH*4-1:0] out_data;
    logic [3:0]             out_keep;

    modport master (
        output in_valid, in_acc, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_keep
    );

    modport slave (
        input  in_valid, in_acc, in_last, out_ready,
        output in_ready, out_valid, out_data, out_keep
    );
endinterface
`default_nettype wire

// File: rtl/conv1d_requant.sv
`default_nettype none
// ============================================================================
// Module   : conv1d_requant
// Purpose  : int32 accumulator to int8 requantizer (Q31 multiply, rounding
//            shift, offset, clamp), packing four results per output word.
// Revision : 1.0  initial release
// ============================================================================
module conv1d_requant #(
    parameter int ACC_WIDTH = 32,
    parameter int OUT_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic signed [ACC_WIDTH-1:0] cfg_multiplier,
    input  logic signed [ACC_WIDTH-1:0] cfg_shift,
    input  logic signed [ACC_WIDTH-1:0] cfg_out_offset,
    input  logic signed [ACC_WIDTH-1:0] cfg_act_min,
    input  logic signed [ACC_WIDTH-1:0] cfg_act_max,
    conv1d_requant_if.slave             bus,
    output logic                        busy
);
    localparam int c_SW = $clog2(ACC_WIDTH);
    localparam int c_PW = 2 * ACC_WIDTH;
    localparam logic signed [c_PW-1:0] c_ONE      = {{(c_PW-1){1'b0}}, 1'b1};
    localparam logic signed [c_PW-1:0] c_HALF     = {{(ACC_WIDTH+1){1'b0}}, 1'b1, {(ACC_WIDTH-2){1'b0}}};
    localparam logic signed [c_PW-1:0] c_NEG_HALF = c_ONE - c_HALF;
    localparam logic signed [c_PW-1:0] c_TRUNC    = {{(ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] c_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic signed [ACC_WIDTH-1:0] c_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0]        c_ONE_A = {{(ACC_WIDTH-1){1'b0}}, 1'b1};

    logic                  w_en, w_take;
    logic [c_SW-1:0]       w_lshift, w_rshift;

    assign w_en        = !bus.out_valid | bus.out_ready;
    assign bus.in_ready = w_en & ~reset;
    assign w_take      = bus.in_valid & bus.in_ready;
    assign w_lshift    = (cfg_shift > 0) ? c_SW'(cfg_shift) : '0;
    assign w_rshift    = (cfg_shift < 0) ? c_SW'(-cfg_shift) : '0;

    // S1: left shift; S2 multiply (product registered before the rounding divide); S3 output byte
    logic                        r_s1_valid, r_s1_last;
    logic signed [ACC_WIDTH-1:0] r_s1_x;
    logic                        r_mul_valid, r_mul_last, r_mul_sat;
    logic signed [c_PW-1:0]      r_mul_prod;
    logic                        r_s2_valid, r_s2_last;
    logic signed [ACC_WIDTH-1:0] r_s2_h;
    logic                        r_s3_valid, r_s3_last;
    logic [OUT_WIDTH-1:0]        r_s3_byte;

    logic signed [c_PW-1:0]      w_x_ext, w_m_ext, w_sum;
    logic signed [ACC_WIDTH-1:0] w_h, w_sh, w_r;
    logic [ACC_WIDTH-1:0]        w_mask, w_rem, w_thr;
    logic                        w_up;
    logic signed [ACC_WIDTH:0]   w_off, w_min, w_max, w_lo, w_cl;
    logic [OUT_WIDTH-1:0]        w_byte;

    assign w_x_ext = {{ACC_WIDTH{r_s1_x[ACC_WIDTH-1]}}, r_s1_x};
    assign w_m_ext = {{ACC_WIDTH{cfg_multiplier[ACC_WIDTH-1]}}, cfg_multiplier};
    assign w_sum   = r_mul_prod + ((r_mul_prod >= 0) ? c_HALF : c_NEG_HALF);
    // Arithmetic shift floors, so negative sums are biased to truncate toward zero
    assign w_h     = r_mul_sat ? c_MAX :
                     ACC_WIDTH'(w_sum[c_PW-1] ? ((w_sum + c_TRUNC) >>> (ACC_WIDTH-1))
                                              : (w_sum >>> (ACC_WIDTH-1)));

    assign w_mask = (c_ONE_A << w_rshift) - c_ONE_A;
    assign w_rem  = r_s2_h & w_mask;
    assign w_thr  = (w_mask >> 1) + {{(ACC_WIDTH-1){1'b0}}, r_s2_h[ACC_WIDTH-1]};
    assign w_up   = (w_rem > w_thr);
    assign w_sh   = r_s2_h >>> w_rshift;
    assign w_r    = w_sh + $signed({{(ACC_WIDTH-1){1'b0}}, w_up});
    assign w_off  = {w_r[ACC_WIDTH-1], w_r} + {cfg_out_offset[ACC_WIDTH-1], cfg_out_offset};
    assign w_min  = {cfg_act_min[ACC_WIDTH-1], cfg_act_min};
    assign w_max  = {cfg_act_max[ACC_WIDTH-1], cfg_act_max};
    // Upper bound applied last so an inverted range resolves to act_max
    assign w_lo   = (w_off < w_min) ? w_min : w_off;
    assign w_cl   = (w_lo > w_max) ? w_max : w_lo;
    assign w_byte = OUT_WIDTH'(w_cl);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid  <= 1'b0;
            r_s1_last   <= 1'b0;
            r_s1_x      <= '0;
            r_mul_valid <= 1'b0;
            r_mul_last  <= 1'b0;
            r_mul_sat   <= 1'b0;
            r_mul_prod  <= '0;
            r_s2_valid  <= 1'b0;
            r_s2_last   <= 1'b0;
            r_s2_h      <= '0;
            r_s3_valid  <= 1'b0;
            r_s3_last   <= 1'b0;
            r_s3_byte   <= '0;
        end else if (w_en) begin
            r_s1_valid  <= w_take;
            if (w_take) begin
                r_s1_x    <= bus.in_acc << w_lshift;
                r_s1_last <= bus.in_last;
            end
            r_mul_valid <= r_s1_valid;
            r_mul_last  <= r_s1_last;
            r_mul_sat   <= (r_s1_x == c_MIN) && (cfg_multiplier == c_MIN);
            r_mul_prod  <= w_x_ext * w_m_ext;
            r_s2_valid  <= r_mul_valid;
            r_s2_last   <= r_mul_last;
            r_s2_h      <= w_h;
            r_s3_valid  <= r_s2_valid;
            r_s3_last   <= r_s2_last;
            r_s3_byte   <= w_byte;
        end
    end

    logic [1:0]             r_idx;
    logic                   r_valid;
    logic [OUT_WIDTH*4-1:0] r_data, w_base_data, w_next_data;
    logic [3:0]             r_keep, w_base_keep, w_next_keep;
    logic                   w_done;

    assign w_done = (r_idx == 2'd3) | r_s3_last;

    // A held word is only left behind when en is high, i.e. it is being drained
    always_comb begin
        w_base_data = r_valid ? '0 : r_data;
        w_base_keep = r_valid ? 4'b0000 : r_keep;
        w_next_data = w_base_data;
        w_next_keep = w_base_keep;
        for (int k = 0; k < 4; k++) begin
            if (r_idx == 2'(k)) begin
                w_next_data[k*OUT_WIDTH +: OUT_WIDTH] = r_s3_byte;
                w_next_keep[k]                        = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx   <= 2'd0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_keep  <= 4'b0000;
        end else if (w_en) begin
            if (r_s3_valid) begin
                r_data  <= w_next_data;
                r_keep  <= w_next_keep;
                r_valid <= w_done;
                r_idx   <= w_done ? 2'd0 : r_idx + 2'd1;
            end else begin
                r_data  <= w_base_data;
                r_keep  <= w_base_keep;
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.out_valid = r_valid;
    assign bus.out_data  = r_data;
    assign bus.out_keep  = r_keep;
    assign busy = r_s1_valid | r_mul_valid | r_s2_valid | r_s3_valid | r_valid | (r_idx != 2'd0);
endmodule
`default_nettype wire

// File: tb/tb_conv1d_requant.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv1d_requant
// Purpose  : Directed self-checking bench for conv1d_requant.
// Revision : 1.0  initial release
// ============================================================================
module tb_conv1d_requant;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [31:0] cfg_multiplier, cfg_shift, cfg_out_offset, cfg_act_min, cfg_act_max;
    logic        busy;

    conv1d_requant_if #(.ACC_WIDTH(32), .OUT_WIDTH(8)) bus ();

    conv1d_requant #(.ACC_WIDTH(32), .OUT_WIDTH(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .cfg_multiplier (cfg_multiplier),
        .cfg_shift      (cfg_shift),
        .cfg_out_offset (cfg_out_offset),
        .cfg_act_min    (cfg_act_min),
        .cfg_act_max    (cfg_act_max),
        .bus            (bus),
        .busy           (busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] feed [16];
    int          feed_n, feed_idx;
    bit          feed_last;
    logic [31:0] got_data [$];
    logic [3:0]  got_keep [$];
    int          edge_cnt, acc_edge, vld_edge, stall_steps;
    logic [31:0] exp_d [4];
    logic [3:0]  exp_k [4];
    int          exp_n;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_cfg(input logic [31:0] m, input logic [31:0] sh, input logic [31:0] off,
                           input logic [31:0] mn, input logic [31:0] mx);
        cfg_multiplier = m;
        cfg_shift      = sh;
        cfg_out_offset = off;
        cfg_act_min    = mn;
        cfg_act_max    = mx;
    endtask

    // One clock: drive at negedge, observe the handshakes the next posedge will perform
    task automatic step(input bit ordy);
        @(negedge clk);
        bus.out_ready = ordy;
        if (feed_idx < feed_n) begin
            bus.in_valid = 1'b1;
            bus.in_acc   = feed[feed_idx];
            bus.in_last  = feed_last && (feed_idx == feed_n - 1);
        end else begin
            bus.in_valid = 1'b0;
            bus.in_last  = 1'b0;
        end
        #1;
        if (bus.out_valid && vld_edge < 0) vld_edge = edge_cnt - 1;
        if (bus.out_valid && bus.out_ready) begin
            got_data.push_back(bus.out_data);
            got_keep.push_back(bus.out_keep);
        end
        if (bus.in_valid && !bus.in_ready) stall_steps++;
        if (bus.in_valid && bus.in_ready) begin
            if (acc_edge < 0) acc_edge = edge_cnt;
            feed_idx++;
        end
        edge_cnt++;
    endtask

    task automatic reset_run_state();
        got_data.delete();
        got_keep.delete();
        feed_idx    = 0;
        edge_cnt    = 0;
        acc_edge    = -1;
        vld_edge    = -1;
        stall_steps = 0;
    endtask

    task automatic run(input string tag, input int stall_at, input int stall_len);
        bit done = 1'b0;
        reset_run_state();
        for (int s = 0; s < 300 && !done; s++) begin
            step(!(s >= stall_at && s < stall_at + stall_len));
            if (feed_idx == feed_n && !bus.in_valid && !busy) done = 1'b1;
        end
        check($sformatf("%s_drain", tag), done, 1);
    endtask

    task automatic check_words(input string tag);
        check($sformatf("%s_count", tag), got_data.size(), exp_n);
        for (int i = 0; i < exp_n; i++) begin
            check($sformatf("%s_data%0d", tag, i), (i < got_data.size()) ? got_data[i] : 32'hxxxxxxxx, exp_d[i]);
            check($sformatf("%s_keep%0d", tag, i), (i < got_keep.size()) ? got_keep[i] : 4'hx, exp_k[i]);
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_acc    = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        feed_n        = 0;
        feed_last     = 1'b0;
        set_cfg(32'h4000_0000, -32'sd2, -32'sd128, -32'sd128, 32'sd127);
        repeat (3) @(negedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_keep", bus.out_keep, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;

        // 1000 * 0.5 = 500, /4 = 125, -128 -> -3
        feed[0] = 32'd1000; feed_n = 1; feed_last = 1'b1;
        run("single", 1000, 0);
        exp_n = 1; exp_d[0] = 32'h0000_00FD; exp_k[0] = 4'b0001;
        check_words("single");
        check("single_latency", vld_edge - acc_edge, 4);

        // Halves round away from zero: 1.5->2, 2.5->3, -1.5->-2, -2.5->-3
        set_cfg(32'h4000_0000, -32'sd1, 32'sd0, -32'sd128, 32'sd127);
        feed[0] = 32'd6; feed[1] = 32'd10; feed[2] = -32'sd6; feed[3] = -32'sd10;
        feed_n = 4; feed_last = 1'b1;
        run("round", 1000, 0);
        exp_n = 1; exp_d[0] = 32'hFDFE_0302; exp_k[0] = 4'hF;
        check_words("round");

        // Saturating product, near-max positive, large negative
        set_cfg(32'h8000_0000, 32'sd0, 32'sd0, -32'sd128, 32'sd127);
        feed[0] = 32'h8000_0000; feed[1] = 32'h8000_0001; feed[2] = 32'h0010_0000;
        feed_n = 3; feed_last = 1'b1;
        run("sat", 1000, 0);
        exp_n = 1; exp_d[0] = 32'h0080_7F7F; exp_k[0] = 4'b0111;
        check_words("sat");

        // Left shift +1 with 0.5 multiplier is identity
        set_cfg(32'h4000_0000, 32'sd1, 32'sd0, -32'sd128, 32'sd127);
        for (int i = 0; i < 9; i++) feed[i] = 32'(4 * (i + 1));
        feed_n = 9; feed_last = 1'b1;
        run("pack", 1000, 0);
        exp_n = 3;
        exp_d[0] = 32'h100C_0804; exp_k[0] = 4'hF;
        exp_d[1] = 32'h201C_1814; exp_k[1] = 4'hF;
        exp_d[2] = 32'h0000_0024; exp_k[2] = 4'b0001;
        check_words("pack");

        // Offset +3 and clamp to [-5,5]: 1->4, 10->5, -20->-5, 0->3
        set_cfg(32'h4000_0000, 32'sd1, 32'sd3, -32'sd5, 32'sd5);
        feed[0] = 32'd1; feed[1] = 32'd10; feed[2] = -32'sd20; feed[3] = 32'd0;
        feed_n = 4; feed_last = 1'b1;
        run("clamp", 1000, 0);
        exp_n = 1; exp_d[0] = 32'h03FB_0504; exp_k[0] = 4'hF;
        check_words("clamp");

        // Inverted range resolves to act_max
        set_cfg(32'h4000_0000, 32'sd1, 32'sd0, 32'sd10, 32'sd2);
        feed[0] = 32'd0; feed_n = 1; feed_last = 1'b1;
        run("inv", 1000, 0);
        exp_n = 1; exp_d[0] = 32'h0000_0002; exp_k[0] = 4'b0001;
        check_words("inv");

        // Backpressure mid-stream
        set_cfg(32'h4000_0000, 32'sd1, 32'sd0, -32'sd128, 32'sd127);
        for (int i = 0; i < 12; i++) feed[i] = 32'(i + 1);
        feed_n = 12; feed_last = 1'b1;
        run("bp", 5, 6);
        exp_n = 3;
        exp_d[0] = 32'h0403_0201; exp_k[0] = 4'hF;
        exp_d[1] = 32'h0807_0605; exp_k[1] = 4'hF;
        exp_d[2] = 32'h0C0B_0A09; exp_k[2] = 4'hF;
        check_words("bp");
        check("bp_in_ready_drop", stall_steps > 0, 1);

        // Asynchronous reset with data in flight
        feed[0] = 32'd17; feed[1] = 32'd18; feed_n = 2; feed_last = 1'b0;
        reset_run_state();
        for (int s = 0; s < 6; s++) step(1'b1);
        check("pre_rst_busy", busy, 1);
        check("pre_rst_keep", bus.out_keep, 4'b0001);
        check("pre_rst_data", bus.out_data, 32'h0000_0011);
        #2;
        reset = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_out_valid", bus.out_valid, 0);
        check("arst_out_data", bus.out_data, 0);
        check("arst_out_keep", bus.out_keep, 0);
        check("arst_in_ready", bus.in_ready, 0);
        feed_n = 0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        feed[0] = 32'd34; feed_n = 1; feed_last = 1'b1;
        run("post_rst", 1000, 0);
        exp_n = 1; exp_d[0] = 32'h0000_0022; exp_k[0] = 4'b0001;
        check_words("post_rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
